trace_retire_buf: RTL and testbench

- Sits directly downstream of Proc's trace ports, consuming trace_addr, trace_inst, trace_stall, trace_squash and trace_data.
- Rebuilds the F→D→X→M→W instruction flow with per-stage valid bits, so each retiring instruction is identified at W.
- Each retired {addr, inst, data} is captured into a FIFO that the bench or a debug port drains through a val/rdy interface.
- Also maintains a retire counter and a sticky overflow flag.

---
 rtl/trace_retire_buf_pkg.sv | 23 ++
 rtl/trace_retire_buf_if.sv | 13 +
 rtl/trace_retire_buf_fifo.sv | 88 ++++++++
 rtl/trace_retire_buf.sv | 103 ++++++++++
 tb/tb_trace_retire_buf.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_retire_buf_pkg.sv
// Shared types for the trace retire buffer: rebuilt pipeline stage records and
// the retired-instruction entries held in the capture FIFO.
package TraceBufPkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] data;
  } trace_entry_t;

  typedef struct packed {
    logic        val;
    logic [31:0] addr;
    logic [31:0] inst;
  } stage_t;

  localparam stage_t BUBBLE = '{val: 1'b0, addr: 32'h0, inst: 32'h0};

  function automatic trace_entry_t make_entry(input stage_t s, input logic [31:0] wb_data);
    make_entry = '{addr: s.addr, inst: s.inst, data: wb_data};
  endfunction

endpackage

// File: rtl/trace_retire_buf_if.sv
// Dequeue side of the retire buffer: a val/rdy stream of {addr, inst, data}.
interface trace_retire_buf_if;

  logic        val;
  logic        rdy;
  logic [31:0] addr;
  logic [31:0] inst;
  logic [31:0] data;

  modport master (output val, output addr, output inst, output data, input rdy);
  modport slave  (input val, input addr, input inst, input data, output rdy);

endinterface

// File: rtl/trace_retire_buf_fifo.sv
// DEPTH-entry val/rdy FIFO of trace entries with registered head outputs,
// occupancy count and a pulse when a push is refused because it is full.
module trace_fifo
  import TraceBufPkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_val,
  input  trace_entry_t           push_entry,
  input  logic                   pop_rdy,
  output logic                   pop_val,
  output trace_entry_t           pop_entry,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trace_entry_t  mem_q [DEPTH];
  trace_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  trace_entry_t  head_q, head_d;
  logic          head_val_q, head_val_d;
  logic          full;
  logic          deq;
  logic          push_ok;

  // The head register is loaded from the next-state memory so an entry
  // written into an empty FIFO shows up exactly one cycle later.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    deq      = head_val_q && pop_rdy;
    push_ok  = push_val && (!full || deq);
    drop     = push_val && full && !deq;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push_ok, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    head_val_d = (count_d != '0);
    head_d     = head_val_d ? mem_d[rd_ptr_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      head_val_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      head_val_q <= head_val_d;
    end
  end

  // Storage needs no reset: nothing is read from it unless the count says so.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pop_val   = head_val_q;
  assign pop_entry = head_q;
  assign count     = count_q;

endmodule

// File: rtl/trace_retire_buf.sv
// Rebuilds Proc's F/D/X/M/W flow from its trace ports, counts every retirement
// and captures retired {addr, inst, data} into a drainable FIFO.
module trace_retire_buf
  import TraceBufPkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            trace_addr,
  input  logic [31:0]            trace_inst,
  input  logic                   trace_stall,
  input  logic                   trace_squash,
  input  logic [31:0]            trace_data,
  input  logic                   rec_en,
  input  logic                   ovf_clr,
  trace_retire_buf_if.master     deq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [31:0]            retire_cnt
);

  stage_t       f_stage;
  stage_t       d_q, d_d;
  stage_t       x_q, x_d;
  stage_t       m_q, m_d;
  stage_t       w_q, w_d;
  logic [31:0]  retire_cnt_q, retire_cnt_d;
  logic         overflow_q, overflow_d;
  logic         push_val;
  trace_entry_t push_entry;
  logic         fifo_drop;
  logic         fifo_val;
  trace_entry_t fifo_head;

  assign f_stage = '{val: 1'b1, addr: trace_addr, inst: trace_inst};

  // Squash outranks stall in D; either one injects a bubble into X.
  always_comb begin
    d_d = d_q;
    if (trace_squash) begin
      d_d = BUBBLE;
    end else if (!trace_stall) begin
      d_d = f_stage;
    end
    x_d = (trace_squash || trace_stall) ? BUBBLE : d_q;
    m_d = x_q;
    w_d = m_q;
  end

  always_comb begin
    retire_cnt_d = retire_cnt_q + 32'(w_q.val);
    push_val     = w_q.val && rec_en;
    push_entry   = make_entry(w_q, trace_data);
    overflow_d   = overflow_q;
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (fifo_drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      d_q          <= BUBBLE;
      x_q          <= BUBBLE;
      m_q          <= BUBBLE;
      w_q          <= BUBBLE;
      retire_cnt_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      d_q          <= d_d;
      x_q          <= x_d;
      m_q          <= m_d;
      w_q          <= w_d;
      retire_cnt_q <= retire_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_val   (push_val),
    .push_entry (push_entry),
    .pop_rdy    (deq.rdy),
    .pop_val    (fifo_val),
    .pop_entry  (fifo_head),
    .count      (count),
    .drop       (fifo_drop)
  );

  assign deq.val    = fifo_val;
  assign deq.addr   = fifo_head.addr;
  assign deq.inst   = fifo_head.inst;
  assign deq.data   = fifo_head.data;
  assign overflow   = overflow_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_trace_retire_buf.sv
// Directed bench for trace_retire_buf: each scenario drives Proc-style trace
// vectors cycle by cycle and checks the dequeued stream against hand values.
module tb_trace_retire_buf;
  import TraceBufPkg::*;

  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [31:0] I0  = 32'h0010_0093;
  localparam logic [31:0] I1  = 32'h0020_0113;
  localparam logic [31:0] I2  = 32'h0030_0193;
  localparam logic [31:0] I3  = 32'h0040_0213;
  localparam logic [31:0] JAL = 32'h1000_006F;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   trace_addr, trace_inst, trace_data;
  logic          trace_stall, trace_squash;
  logic          rec_en, ovf_clr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   retire_cnt;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [31:0]   exp_retire;

  trace_retire_buf_if deq_if ();

  trace_retire_buf #(
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .trace_addr   (trace_addr),
    .trace_inst   (trace_inst),
    .trace_stall  (trace_stall),
    .trace_squash (trace_squash),
    .trace_data   (trace_data),
    .rec_en       (rec_en),
    .ovf_clr      (ovf_clr),
    .deq          (deq_if),
    .count        (count),
    .overflow     (overflow),
    .retire_cnt   (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of Proc trace activity; returns 1ns after the closing edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] i, input logic st,
                       input logic sq, input logic [31:0] d);
    trace_addr   = a;
    trace_inst   = i;
    trace_stall  = st;
    trace_squash = sq;
    trace_data   = d;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b0; rec_en = 1'b1; ovf_clr = 1'b0; deq_if.rdy = 1'b0;
    trace_addr = '0; trace_inst = '0; trace_data = '0; trace_stall = 1'b0; trace_squash = 1'b1;
    repeat (3) step();
    n_cmp++; if ({deq_if.val, deq_if.addr, deq_if.inst, deq_if.data} !== 97'h0) begin
      n_bad++; $display("[TB] FAIL reset_deq: got %h want 0", {deq_if.val, deq_if.addr, deq_if.inst, deq_if.data}); end
    n_cmp++; if (count !== '0) begin n_bad++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (retire_cnt !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_retire: got %0d want 0", retire_cnt); end
    rst = 1'b1;
    idle(5);
    n_cmp++; if (deq_if.val !== 1'b0 || retire_cnt !== 32'h0) begin
      n_bad++; $display("[TB] FAIL idle_after_reset: got val=%b retire=%0d want val=0 retire=0", deq_if.val, retire_cnt); end
    exp_retire = 32'd0;
  endtask

  task automatic test_straight();
    deq_if.rdy = 1'b1;
    drive(32'h200, I0, 1'b0, 1'b0, 32'h0);
    drive(32'h204, I1, 1'b0, 1'b0, 32'h0);
    drive(32'h208, I2, 1'b0, 1'b0, 32'h0);
    drive(32'h20C, 32'h0, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (deq_if.val !== 1'b0 || count !== '0) begin
      n_bad++; $display("[TB] FAIL straight_no_bypass: got val=%b count=%0d want 0/0", deq_if.val, count); end
    drive(32'h0, 32'h0, 1'b0, 1'b1, 32'hD000_0200);
    n_cmp++; if ({deq_if.val, deq_if.addr, deq_if.inst, deq_if.data} !== {1'b1, 32'h200, I0, 32'hD000_0200}) begin
      n_bad++; $display("[TB] FAIL straight_0: got %h %h %h %h", deq_if.val, deq_if.addr, deq_if.inst, deq_if.data); end
    n_cmp++; if (count !== CW'(1)) begin n_bad++; $display("[TB] FAIL straight_count: got %0d want 1", count); end
    drive(32'h0, 32'h0, 1'b0, 1'b1, 32'hD000_0204);
    n_cmp++; if ({deq_if.val, deq_if.addr, deq_if.inst, deq_if.data} !== {1'b1, 32'h204, I1, 32'hD000_0204}) begin
      n_bad++; $display("[TB] FAIL straight_1: got %h %h %h %h", deq_if.val, deq_if.addr, deq_if.inst, deq_if.data); end
    drive(32'h0, 32'h0, 1'b0, 1'b1, 32'hD000_0208);
    n_cmp++; if ({deq_if.val, deq_if.addr, deq_if.inst, deq_if.data} !== {1'b1, 32'h208, I2, 32'hD000_0208}) begin
      n_bad++; $display("[TB] FAIL straight_2: got %h %h %h %h", deq_if.val, deq_if.addr, deq_if.inst, deq_if.data); end
    exp_retire = exp_retire + 32'd3;
    n_cmp++; if (retire_cnt !== exp_retire) begin n_bad++; $display("[TB] FAIL straight_retire: got %0d want %0d", retire_cnt, exp_retire); end
    idle(1);
    n_cmp++; if (deq_if.val !== 1'b0) begin n_bad++; $display("[TB] FAIL straight_drained: got val=%b want 0", deq_if.val); end
  endtask

  task automatic test_stall();
    deq_if.rdy = 1'b1;
    drive(32'h200, I0, 1'b0, 1'b0, 32'h0);
    drive(32'h204, I1, 1'b0, 1'b0, 32'h0);
    drive(32'h208, I2, 1'b1, 1'b0, 32'h0);
    drive(32'h208, I2, 1'b1, 1'b0, 32'h0);
    drive(32'h208, I2, 1'b0, 1'b0, 32'h5000_0000);
    n_cmp++; if ({deq_if.val, deq_if.addr, deq_if.data} !== {1'b1, 32'h200, 32'h5000_0000}) begin
      n_bad++; $display("[TB] FAIL stall_0: got %h %h %h", deq_if.val, deq_if.addr, deq_if.data); end
    drive(32'h20C, 32'h0, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (deq_if.val !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_bubble_a: got val=%b want 0", deq_if.val); end
    drive(32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    n_cmp++; if (deq_if.val !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_bubble_b: got val=%b want 0", deq_if.val); end
    drive(32'h0, 32'h0, 1'b0, 1'b1, 32'h5000_0001);
    n_cmp++; if ({deq_if.val, deq_if.addr, deq_if.inst, deq_if.data} !== {1'b1, 32'h204, I1, 32'h5000_0001}) begin
      n_bad++; $display("[TB] FAIL stall_1: got %h %h %h %h", deq_if.val, deq_if.addr, deq_if.inst, deq_if.data); end
    drive(32'h0, 32'h0, 1'b0, 1'b1, 32'h5000_0002);
    n_cmp++; if ({deq_if.val, deq_if.addr, deq_if.inst, deq_if.data} !== {1'b1, 32'h208, I2, 32'h5000_0002}) begin
      n_bad++; $display("[TB] FAIL stall_2: got %h %h %h %h", deq_if.val, deq_if.addr, deq_if.inst, deq_if.data); end
    idle(1);
    exp_retire = exp_retire + 32'd3;
    n_cmp++; if (deq_if.val !== 1'b0 || retire_cnt !== exp_retire) begin
      n_bad++; $display("[TB] FAIL stall_once: got val=%b retire=%0d want 0/%0d", deq_if.val, retire_cnt, exp_retire); end
  endtask

  task automatic test_squash();
    deq_if.rdy = 1'b1;
    drive(32'h200, JAL, 1'b0, 1'b0, 32'h0);
    drive(32'h204, I1, 1'b0, 1'b0, 32'h0);
    drive(32'h208, I2, 1'b0, 1'b1, 32'h0);
    drive(32'h300, I3, 1'b0, 1'b0, 32'h0);
    drive(32'h304, 32'h0, 1'b0, 1'b0, 32'h6000_0000);
    n_cmp++; if ({deq_if.val, deq_if.addr, deq_if.inst, deq_if.data} !== {1'b1, 32'h200, JAL, 32'h6000_0000}) begin
      n_bad++; $display("[TB] FAIL squash_jal: got %h %h %h %h", deq_if.val, deq_if.addr, deq_if.inst, deq_if.data); end
    drive(32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    n_cmp++; if (deq_if.val !== 1'b0) begin n_bad++; $display("[TB] FAIL squash_killed_a: got val=%b want 0", deq_if.val); end
    drive(32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    n_cmp++; if (deq_if.val !== 1'b0) begin n_bad++; $display("[TB] FAIL squash_killed_b: got val=%b want 0", deq_if.val); end
    drive(32'h0, 32'h0, 1'b0, 1'b1, 32'h6000_0001);
    n_cmp++; if ({deq_if.val, deq_if.addr, deq_if.inst, deq_if.data} !== {1'b1, 32'h300, I3, 32'h6000_0001}) begin
      n_bad++; $display("[TB] FAIL squash_target: got %h %h %h %h", deq_if.val, deq_if.addr, deq_if.inst, deq_if.data); end
    idle(1);
    exp_retire = exp_retire + 32'd2;
    n_cmp++; if (deq_if.val !== 1'b0 || retire_cnt !== exp_retire) begin
      n_bad++; $display("[TB] FAIL squash_count: got val=%b retire=%0d want 0/%0d", deq_if.val, retire_cnt, exp_retire); end
  endtask

  task automatic test_rec_disable();
    deq_if.rdy = 1'b1;
    rec_en = 1'b0;
    drive(32'h800, I0, 1'b0, 1'b0, 32'h0);
    drive(32'h804, 32'h0, 1'b0, 1'b0, 32'h0);
    idle(4);
    exp_retire = exp_retire + 32'd1;
    n_cmp++; if (deq_if.val !== 1'b0 || count !== '0 || retire_cnt !== exp_retire) begin
      n_bad++; $display("[TB] FAIL rec_disabled: got val=%b count=%0d retire=%0d want 0/0/%0d",
                        deq_if.val, count, retire_cnt, exp_retire); end
    rec_en = 1'b1;
  endtask

  task automatic test_overflow();
    logic [31:0] a, i;
    deq_if.rdy = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c == 20) begin
        n_cmp++; if (count !== CW'(DEPTH) || overflow !== 1'b0) begin
          n_bad++; $display("[TB] FAIL ovf_just_full: got count=%0d ovf=%b want %0d/0", count, overflow, DEPTH); end
      end
      ovf_clr = (c == 21);
      a = (c < 18) ? 32'h400 + 32'(4 * c) : ((c == 18) ? 32'h900 : 32'h0);
      i = (c < 18) ? 32'h1000 + 32'(c) : 32'h0;
      drive(a, i, 1'b0, (c >= 19), 32'hA000_0000 + 32'(c) - 32'd4);
      if (c == 21) begin
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_clr_vs_drop: got %b want 1", overflow); end
      end
    end
    ovf_clr = 1'b0;
    exp_retire = exp_retire + 32'd18;
    n_cmp++; if (count !== CW'(DEPTH) || overflow !== 1'b1 || retire_cnt !== exp_retire) begin
      n_bad++; $display("[TB] FAIL ovf_state: got count=%0d ovf=%b retire=%0d want %0d/1/%0d",
                        count, overflow, retire_cnt, DEPTH, exp_retire); end
    n_cmp++; if ({deq_if.val, deq_if.addr, deq_if.inst, deq_if.data} !== {1'b1, 32'h400, 32'h1000, 32'hA000_0000}) begin
      n_bad++; $display("[TB] FAIL ovf_head: got %h %h %h %h", deq_if.val, deq_if.addr, deq_if.inst, deq_if.data); end
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b0 || count !== CW'(DEPTH)) begin
      n_bad++; $display("[TB] FAIL ovf_cleared: got ovf=%b count=%0d want 0/%0d", overflow, count, DEPTH); end
  endtask

  task automatic test_full_push_deq();
    deq_if.rdy = 1'b0;
    drive(32'h500, I0, 1'b0, 1'b0, 32'h0);
    drive(32'h504, I1, 1'b0, 1'b0, 32'h0);
    drive(32'h508, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    deq_if.rdy = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b1, 32'hB000_0000);
    n_cmp++; if (count !== CW'(DEPTH) || deq_if.addr !== 32'h404 || deq_if.data !== 32'hA000_0001) begin
      n_bad++; $display("[TB] FAIL full_pd_first: got count=%0d addr=%h data=%h want %0d/404/a0000001",
                        count, deq_if.addr, deq_if.data, DEPTH); end
    drive(32'h0, 32'h0, 1'b0, 1'b1, 32'hB000_0004);
    n_cmp++; if (count !== CW'(DEPTH) || overflow !== 1'b0) begin
      n_bad++; $display("[TB] FAIL full_pd_no_drop: got count=%0d ovf=%b want %0d/0", count, overflow, DEPTH); end
    for (int k = 2; k < DEPTH; k++) begin
      n_cmp++; if ({deq_if.val, deq_if.addr, deq_if.inst, deq_if.data} !==
                   {1'b1, 32'h400 + 32'(4 * k), 32'h1000 + 32'(k), 32'hA000_0000 + 32'(k)}) begin
        n_bad++; $display("[TB] FAIL drain_%0d: got %h %h %h %h", k, deq_if.val, deq_if.addr, deq_if.inst, deq_if.data); end
      idle(1);
    end
    n_cmp++; if ({deq_if.val, deq_if.addr, deq_if.inst, deq_if.data} !== {1'b1, 32'h500, I0, 32'hB000_0000}) begin
      n_bad++; $display("[TB] FAIL drain_new0: got %h %h %h %h", deq_if.val, deq_if.addr, deq_if.inst, deq_if.data); end
    idle(1);
    n_cmp++; if ({deq_if.val, deq_if.addr, deq_if.inst, deq_if.data} !== {1'b1, 32'h504, I1, 32'hB000_0004}) begin
      n_bad++; $display("[TB] FAIL drain_new1: got %h %h %h %h", deq_if.val, deq_if.addr, deq_if.inst, deq_if.data); end
    idle(1);
    exp_retire = exp_retire + 32'd2;
    n_cmp++; if (deq_if.val !== 1'b0 || count !== '0 || retire_cnt !== exp_retire) begin
      n_bad++; $display("[TB] FAIL drain_empty: got val=%b count=%0d retire=%0d want 0/0/%0d",
                        deq_if.val, count, retire_cnt, exp_retire); end
  endtask

  task automatic test_reset_mid();
    deq_if.rdy = 1'b0;
    for (int c = 0; c < 7; c++) begin
      drive(32'h600 + 32'(4 * c), 32'h2000 + 32'(c), 1'b0, 1'b0, 32'hC000_0000 + 32'(c));
    end
    n_cmp++; if (count !== CW'(3)) begin n_bad++; $display("[TB] FAIL mid_queued: got %0d want 3", count); end
    rst = 1'b0;
    drive(32'h61C, 32'h2007, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    exp_retire = 32'd0;
    n_cmp++; if (deq_if.val !== 1'b0 || count !== '0 || retire_cnt !== 32'h0 || overflow !== 1'b0) begin
      n_bad++; $display("[TB] FAIL mid_reset: got val=%b count=%0d retire=%0d ovf=%b want all 0",
                        deq_if.val, count, retire_cnt, overflow); end
    deq_if.rdy = 1'b1;
    drive(32'h700, I0, 1'b0, 1'b0, 32'h0);
    drive(32'h704, 32'h0, 1'b0, 1'b0, 32'h0);
    idle(2);
    n_cmp++; if (deq_if.val !== 1'b0 || retire_cnt !== 32'h0) begin
      n_bad++; $display("[TB] FAIL mid_stale: got val=%b retire=%0d want 0/0", deq_if.val, retire_cnt); end
    drive(32'h0, 32'h0, 1'b0, 1'b1, 32'hE000_0700);
    n_cmp++; if ({deq_if.val, deq_if.addr, deq_if.inst, deq_if.data} !== {1'b1, 32'h700, I0, 32'hE000_0700}) begin
      n_bad++; $display("[TB] FAIL mid_first: got %h %h %h %h", deq_if.val, deq_if.addr, deq_if.inst, deq_if.data); end
    n_cmp++; if (retire_cnt !== 32'd1) begin n_bad++; $display("[TB] FAIL mid_retire: got %0d want 1", retire_cnt); end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_stall();
    test_squash();
    test_rec_disable();
    test_overflow();
    test_full_push_deq();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
